// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor: counter
// encoding, BTB entry layout and the 2-bit saturating counter step.
package bp_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Tag field is sized for the widest legal TAG_BITS; unused high bits stay 0.
  localparam int BP_TAG_W    = 30;
  localparam int BP_TARGET_W = 30;

  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_W-1:0]    tag;
    logic [BP_TARGET_W-1:0] target;
    logic [1:0]             ctr;
  } bp_entry_t;

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == ST) ? ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_counter32.sv
// Saturating event counter with increment enable; holds at all-ones.
// Width defaults to 32 for the predictor's performance counters.
module bp_sat_counter32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. Zero-latency lookup of
// the fetch PC; trained by execute-stage conditional branch resolutions.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  bp_entry_t tbl_q [ENTRIES];
  bp_entry_t tbl_d [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [BP_TAG_W-1:0] fetch_tag;
  logic [BP_TAG_W-1:0] upd_tag;
  bp_entry_t           fetch_ent;
  bp_entry_t           upd_ent;
  logic                fetch_hit;
  logic                upd_hit;
  logic                upd_en;
  logic                mispredict;
  logic                unused_bits;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = BP_TAG_W'(fetch_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]);
  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_tag   = BP_TAG_W'(upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]);

  // Byte-offset bits and PC bits above the tag play no part in prediction.
  assign unused_bits = ^{upd_pc, upd_target[1:0]};

  assign upd_en     = upd_valid & ena;
  assign mispredict = upd_en & (upd_taken ^ upd_pred_taken);

  always_comb begin
    fetch_ent   = tbl_q[fetch_idx];
    fetch_hit   = fetch_ent.valid && (fetch_ent.tag == fetch_tag);
    pred_taken  = fetch_hit && fetch_ent.ctr[1] && !reset;
    pred_target = pred_taken ? {fetch_ent.target, 2'b00} : fetch_pc + 32'd4;
  end

  // Training: the lookup above reads tbl_q, so a same-cycle update is not bypassed.
  always_comb begin
    tbl_d   = tbl_q;
    upd_ent = tbl_q[upd_idx];
    upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);
    if (upd_en) begin
      if (upd_hit) begin
        tbl_d[upd_idx].ctr = sat_ctr(upd_ent.ctr, upd_taken);
        if (upd_taken) begin
          tbl_d[upd_idx].target = upd_target[31:2];
        end
      end else if (upd_taken) begin
        tbl_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target[31:2], ctr: WT};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  bp_sat_counter32 #(.W(32)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (upd_en),
    .count (branch_count)
  );

  bp_sat_counter32 #(.W(32)) u_mispredict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mispredict),
    .count (mispredict_count)
  );

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side conditional-branch predictor, paired with the execute-stage jump/branch resolver.
- Each cycle it looks up the fetch PC and supplies a taken/not-taken prediction and a target. The prediction bit travels down the pipeline as the "predicted taken" flag (flags[16]).
- When execute resolves a conditional branch, it reports pc, outcome and target back here. That report trains a direct-mapped BTB with 2-bit saturating counters.
- Also keeps resolved-branch and mispredict performance counters.

Parameters:
- ENTRIES, 16, number of BTB/counter entries; power of two, 4..256.
- IDX_BITS, 4, log2(ENTRIES).
- TAG_BITS, 8, PC tag bits stored per entry.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ena  in  1  global enable; 0 = pipeline stall, no state updates.
- fetch_pc  in  32  PC being fetched this cycle.
- pred_taken  out  1  predicted taken for fetch_pc; combinational from table flops.
- pred_target  out  32  predicted target; equals fetch_pc+4 when pred_taken=0.
- upd_valid  in  1  execute resolved a conditional branch this cycle (flags[12]).
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved outcome.
- upd_target  in  32  resolved taken target.
- upd_pred_taken  in  1  prediction carried with that branch (its flags[16]).
- branch_count  out  32  resolved conditional branches, saturating.
- mispredict_count  out  32  resolved branches with upd_taken != upd_pred_taken, saturating.

Behaviour:
- Index is pc[IDX_BITS+1:2]. Tag is pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]. pc[1:0] is ignored.
- Per entry: valid(1), tag(TAG_BITS), target(30, word address, low 2 bits implied 0), ctr(2).
- Counter encoding: SNT=0, WNT=1, WT=2, ST=3.
- Lookup is zero latency: hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = pred_taken ? {target,2'b00} : fetch_pc+4.
- pred_taken/pred_target are driven regardless of ena; outputs during reset are pred_taken=0 and pred_target=fetch_pc+4.
- Updates are applied on the clock edge when upd_valid & ena & !reset:
  - hit, taken: ctr = min(ctr+1, 3); target overwritten with upd_target[31:2].
  - hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - miss, taken: allocate (replacing any occupant): valid=1, tag, target, ctr=WT.
  - miss, not taken: no table change.
- Counter FSM per entry: SNT <-> WNT <-> WT <-> ST, one step per update, saturating at both ends.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update value. There is no bypass; the new value is visible from the next cycle.
- Perf counters also advance only when upd_valid & ena. branch_count +1; mispredict_count +1 if upd_taken != upd_pred_taken. Both hold at 0xFFFFFFFF.
- ena=0: the table and perf counters are frozen; the upd_* inputs are ignored.
- Reset, asynchronous, may arrive mid-operation. All valid=0, all ctr=WNT, tag/target=0, both perf counters=0. Predictions immediately become not-taken. An update coincident with reset is discarded.
- Instructions outside conditional branches are never allocated; execute asserts upd_valid only for flags[12].
- Wrap-around: fetch_pc+4 at 0xFFFFFFFC yields 0x00000000, which is legal.

Decomposition:
- Shared package (bp_pkg) holds:
  - counter encoding constants SNT/WNT/WT/ST;
  - bp_entry_t struct {valid, tag, target, ctr};
  - function sat_ctr(ctr, taken) returning the next counter state.
- One natural sub-module: bp_sat_counter32, a 32-bit saturating incrementer with enable, instantiated twice for the perf counters.
- The table is flop-based inside branch_predictor, not RAM, so the lookup stays zero latency.

Test Plan:
- Reset then lookup fetch_pc=0x00000100 -> pred_taken=0, pred_target=0x00000104; both perf counters 0.
- Update pc=0x100, taken=1, target=0x80, pred=0; next cycle fetch 0x100 -> pred_taken=1, pred_target=0x80 (ctr=WT); mispredict_count=1, branch_count=1.
- On the allocated entry, two not-taken updates (ctr WT->WNT->SNT) -> pred_taken=0. Three taken updates -> ST; a fourth taken stays ST; one not-taken -> WT, still predicted taken.
- Alias test: allocate pc=0x100, then a taken update at pc=0x140 (same index, different tag) -> 0x140 hits with its own target; 0x100 now misses -> pred_taken=0.
- Same-cycle update and lookup of 0x100 while ctr=WT and not taken -> that cycle pred_taken=1; next cycle pred_taken=0. With ena=0, upd_valid=1 -> table and counters unchanged.
- Assert reset asynchronously mid-cycle with populated table and counters=5 -> pred_taken drops to 0 before the next edge; counters read 0. Force branch_count=0xFFFFFFFF, then update -> stays 0xFFFFFFFF.
